// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
//   SEG_0..SEG_9, SEG_BLANK : 8-bit scan-bus patterns {blank, g..a}, active-high
//                              segments. The forward decoder uses the same table.
//   BCD_ERR                 : BCD value reported for an unrecognised pattern.
//   onehot0_index()         : position of the low bit in an active-low one-hot select.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h80;

  localparam logic [3:0] BCD_ERR   = 4'hF;

  // Select is padded to 8 bits with 1s by the caller. For a legal (single low
  // bit) select the result is the index of that bit.
  function automatic logic [2:0] onehot0_index(input logic [7:0] sel_n);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!sel_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// seg7_pattern_to_bcd: combinational inverse 7-segment decoder.
//   seg   in  8  {blank flag, segments g..a}
//   bcd   out 4  decoded digit (0 for blank, BCD_ERR for unknown patterns)
//   blank out 1  pattern is the blank code
//   err   out 1  pattern is not a digit and not blank
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  always_comb begin
    bcd   = '0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default: begin
        bcd = BCD_ERR;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: passive observer of a multiplexed 7-segment scan bus.
// Recovers the BCD value shown on each digit and commits it once the
// {segments, select} sample has been stable for STABLE_CYCLES samples.
//   clk, rst_n   clock / asynchronous active-low reset
//   seg_in       {blank flag, segments g..a}
//   dig_sel_n    active-low one-hot digit select
//   bcd_out      last committed BCD per digit, digit i at [4i+3:4i]
//   blank_mask   digit last committed as blank
//   err_mask     digit last committed with an unrecognised pattern
//   upd_valid    one-cycle pulse per commit; upd_idx/upd_bcd describe it and
//                hold their value between commits
module seven_segment_monitor
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    upd_valid,
  output logic [2:0]              upd_idx,
  output logic [3:0]              upd_bcd
);

  logic [7:0]            seg_s1, seg_s2, prev_seg;
  logic [NUM_DIGITS-1:0] sel_s1, sel_s2, prev_sel;
  logic [7:0]            cnt, cnt_nxt;
  logic [7:0]            sel_pad;
  logic [2:0]            idx;
  logic                  legal, same, commit;
  logic [3:0]            dec_bcd;
  logic                  dec_blank, dec_err;

  seg7_pattern_to_bcd u_dec (
    .seg   (seg_s2),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // Two-stage synchroniser; reset value of all-zero select is illegal, so
  // nothing is counted until real samples arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      sel_s1 <= '0;
      sel_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      sel_s1 <= dig_sel_n;
      sel_s2 <= sel_s1;
    end
  end

  always_comb begin
    sel_pad                 = '1;
    sel_pad[NUM_DIGITS-1:0] = sel_s2;
    idx                     = onehot0_index(sel_pad);
    legal                   = ($countones(~sel_s2) == 1);
    same                    = (seg_s2 == prev_seg) && (sel_s2 == prev_sel);
    cnt_nxt                 = cnt;
    if (!legal)
      cnt_nxt = '0;
    else if (!same)
      cnt_nxt = 8'd1;
    else if (cnt < 8'(STABLE_CYCLES))
      cnt_nxt = cnt + 8'd1;
    // Saturation at STABLE_CYCLES guarantees a single commit per window.
    commit = legal && same && (cnt == 8'(STABLE_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg <= '0;
      prev_sel <= '0;
      cnt      <= '0;
    end else begin
      prev_seg <= seg_s2;
      prev_sel <= sel_s2;
      cnt      <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out    <= '0;
      blank_mask <= '1;
      err_mask   <= '0;
      upd_valid  <= 1'b0;
      upd_idx    <= '0;
      upd_bcd    <= '0;
    end else begin
      upd_valid <= commit;
      if (commit) begin
        upd_idx <= idx;
        upd_bcd <= dec_bcd;
      end
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (commit && (idx == 3'(i))) begin
          bcd_out[4*i +: 4] <= dec_bcd;
          blank_mask[i]     <= dec_blank;
          err_mask[i]       <= dec_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_monitor.sv
module tb_seven_segment_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [7:0]  dig_sel_n;
  logic [31:0] bcd_out;
  logic [7:0]  blank_mask, err_mask;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_bcd;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  int unsigned log_idx[$];
  int unsigned log_bcd[$];
  int unsigned log_cyc[$];

  logic [7:0] pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  seven_segment_monitor #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel_n  (dig_sel_n),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .err_mask   (err_mask),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_bcd    (upd_bcd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (upd_valid) begin
      log_idx.push_back(int'(upd_idx));
      log_bcd.push_back(int'(upd_bcd));
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] seg, input logic [7:0] sel, input int unsigned n);
    seg_in    = seg;
    dig_sel_n = sel;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] sel_of(input int unsigned d);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << d);
  endfunction

  function automatic logic [31:0] q_at(input int unsigned q[$], input int unsigned i);
    if (i < q.size()) return q[i];
    return 32'hFFFF_FFFF;
  endfunction

  int unsigned base;
  int unsigned t0;

  initial begin
    rst_n     = 1'b0;
    seg_in    = 8'h00;
    dig_sel_n = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. idle after reset
    repeat (10) @(negedge clk);
    check("rst_bcd",   bcd_out,    32'h0);
    check("rst_blank", blank_mask, 8'hFF);
    check("rst_err",   err_mask,   8'h00);
    check("rst_ncommit", log_idx.size(), 0);

    // 2. digit 2 shows "2"
    base = log_idx.size();
    t0   = cyc;
    drive(8'h5B, 8'hFB, 10);
    check("t2_ncommit", log_idx.size() - base, 1);
    check("t2_idx", q_at(log_idx, base), 2);
    check("t2_bcd", q_at(log_bcd, base), 2);
    check("t2_latency", q_at(log_cyc, base) - t0, 6);
    check("t2_bcd_out", bcd_out[11:8], 4'h2);
    check("t2_blank", blank_mask, 8'hFB);

    // 3. short "9" then "8" on digit 0
    base = log_idx.size();
    drive(8'h6F, 8'hFE, 3);
    drive(8'h7F, 8'hFE, 8);
    check("t3_ncommit", log_idx.size() - base, 1);
    check("t3_bcd", q_at(log_bcd, base), 8);
    check("t3_idx", q_at(log_idx, base), 0);
    check("t3_bcd_out", bcd_out[3:0], 4'h8);
    check("t3_hold_bcd", upd_bcd, 4'h8);

    // 4. error pattern, then blank, on digit 5
    drive(8'h12, 8'hDF, 10);
    check("t4_err", err_mask, 8'h20);
    check("t4_bcd_out", bcd_out[23:20], 4'hF);
    check("t4_blank", blank_mask, 8'hDA);
    drive(8'h80, 8'hDF, 10);
    check("t4b_err", err_mask, 8'h00);
    check("t4b_blank", blank_mask, 8'hFA);
    check("t4b_bcd_out", bcd_out, 32'h0000_0208);

    // 5. two low select bits: illegal, no commit
    base = log_idx.size();
    drive(8'h06, 8'hF3, 10);
    check("t5_ncommit", log_idx.size() - base, 0);
    check("t5_bcd_out", bcd_out, 32'h0000_0208);
    check("t5_blank", blank_mask, 8'hFA);
    check("t5_err", err_mask, 8'h00);

    // 6. full scan
    base = log_idx.size();
    for (int unsigned d = 0; d < 8; d++) drive(pat[d], sel_of(d), 6);
    drive(8'h00, 8'hFF, 4);
    check("t6_ncommit", log_idx.size() - base, 8);
    for (int unsigned d = 0; d < 8; d++) begin
      check($sformatf("t6_idx%0d", d), q_at(log_idx, base + d), d);
      check($sformatf("t6_val%0d", d), q_at(log_bcd, base + d), d);
    end
    check("t6_bcd_out", bcd_out, 32'h7654_3210);
    check("t6_blank", blank_mask, 8'h00);
    check("t6_err", err_mask, 8'h00);

    // 6b. scan with reset mid-window on digit 3
    base = log_idx.size();
    for (int unsigned d = 0; d < 3; d++) drive(pat[d], sel_of(d), 6);
    drive(pat[3], sel_of(3), 2);
    check("t6b_pre_ncommit", log_idx.size() - base, 3);
    rst_n = 1'b0;
    #1;
    check("t6b_rst_bcd",   bcd_out,    32'h0);
    check("t6b_rst_blank", blank_mask, 8'hFF);
    check("t6b_rst_err",   err_mask,   8'h00);
    check("t6b_rst_upd",   {upd_valid, upd_idx, upd_bcd}, 8'h00);
    base = log_idx.size();
    repeat (6) @(negedge clk);
    check("t6b_no_commit_in_rst", log_idx.size() - base, 0);
    rst_n = 1'b1;
    for (int unsigned d = 3; d < 8; d++) drive(pat[d], sel_of(d), 6);
    drive(8'h00, 8'hFF, 4);
    check("t6b_ncommit", log_idx.size() - base, 5);
    for (int unsigned d = 3; d < 8; d++)
      check($sformatf("t6b_val%0d", d), q_at(log_bcd, base + d - 3), d);
    check("t6b_bcd_out", bcd_out, 32'h7654_3000);
    check("t6b_blank", blank_mask, 8'h07);
    check("t6b_err", err_mask, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
